// File: rtl/amo_lrsc_sequencer.sv
// amo_lrsc_sequencer: runs one AMO at a time as an LR -> compute -> SC sequence with bounded retry.
// Build option AMO_BACKOFF_EN inserts a hart-scaled wait between a failed SC and the next LR.
module amo_lrsc_sequencer #(
  parameter int NUM_THREADS = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_RETRIES = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [$clog2(NUM_THREADS)-1:0] i_req_hart,
  input  logic [ADDR_WIDTH-1:0]          i_req_addr,
  input  logic [3:0]                     i_req_funct,
  input  logic [DATA_WIDTH-1:0]          i_req_operand,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic                           o_mem_we,
  output logic [DATA_WIDTH-1:0]          o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]          i_mem_rdata,
  output logic [ADDR_WIDTH-1:0]          o_rs_addr,
  output logic [$clog2(NUM_THREADS)-1:0] o_rs_mhartid,
  output logic                           o_rs_load_reserved_op,
  output logic                           o_rs_store_cond_op,
  input  logic                           i_rs_sc_success,
  output logic                           o_resp_valid,
  input  logic                           i_resp_ready,
  output logic [$clog2(NUM_THREADS)-1:0] o_resp_hart,
  output logic [DATA_WIDTH-1:0]          o_resp_rdata,
  output logic                           o_resp_fail
);
  localparam int HART_W  = $clog2(NUM_THREADS);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LR,
    S_CALC,
    S_SC,
    S_CHK,
    S_RESP
`ifdef AMO_BACKOFF_EN
    , S_BACKOFF
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [HART_W-1:0]     hart_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            funct_q;
  logic [DATA_WIDTH-1:0] operand_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] new_q;
  logic [RETRY_W-1:0]    retry_q;
  logic                  fail_q;
  logic [DATA_WIDTH-1:0] amo_result;
  logic                  retry_left;

  assign retry_left = (retry_q < RETRY_MAX);

`ifdef AMO_BACKOFF_EN
  localparam int BO_W = HART_W + RETRY_W + 1;
  logic [BO_W-1:0] backoff_q;
  logic [BO_W-1:0] backoff_load;
  // Wait length uses the retry count after this failure is counted; stored as length - 1.
  assign backoff_load = (BO_W'(hart_q) + BO_W'(1)) * (BO_W'(retry_q) + BO_W'(1)) - BO_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_req_valid) state_d = S_LR;
      S_LR:   state_d = S_CALC;
      S_CALC: state_d = S_SC;
      S_SC:   state_d = S_CHK;
      S_CHK: begin
        if (i_rs_sc_success || !retry_left) state_d = S_RESP;
`ifdef AMO_BACKOFF_EN
        else                                state_d = S_BACKOFF;
`else
        else                                state_d = S_LR;
`endif
      end
      S_RESP: if (i_resp_ready) state_d = S_IDLE;
`ifdef AMO_BACKOFF_EN
      S_BACKOFF: if (backoff_q == '0) state_d = S_LR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready           = 1'b0;
    o_rs_load_reserved_op = 1'b0;
    o_rs_store_cond_op    = 1'b0;
    o_mem_we              = 1'b0;
    o_resp_valid          = 1'b0;
    case (state_q)
      S_IDLE: o_req_ready           = 1'b1;
      S_LR:   o_rs_load_reserved_op = 1'b1;
      S_SC:   o_rs_store_cond_op    = 1'b1;
      S_CHK:  o_mem_we              = i_rs_sc_success;
      S_RESP: o_resp_valid          = 1'b1;
      default: ;
    endcase
  end

  // Codes 9..15 fall through to SWAP.
  always_comb begin
    amo_result = operand_q;
    case (funct_q)
      4'd1: amo_result = i_mem_rdata + operand_q;
      4'd2: amo_result = i_mem_rdata ^ operand_q;
      4'd3: amo_result = i_mem_rdata & operand_q;
      4'd4: amo_result = i_mem_rdata | operand_q;
      4'd5: amo_result = ($signed(i_mem_rdata) < $signed(operand_q)) ? i_mem_rdata : operand_q;
      4'd6: amo_result = ($signed(i_mem_rdata) > $signed(operand_q)) ? i_mem_rdata : operand_q;
      4'd7: amo_result = (i_mem_rdata < operand_q) ? i_mem_rdata : operand_q;
      4'd8: amo_result = (i_mem_rdata > operand_q) ? i_mem_rdata : operand_q;
      default: amo_result = operand_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hart_q    <= '0;
      addr_q    <= '0;
      funct_q   <= '0;
      operand_q <= '0;
      old_q     <= '0;
      new_q     <= '0;
      retry_q   <= '0;
      fail_q    <= 1'b0;
`ifdef AMO_BACKOFF_EN
      backoff_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            hart_q    <= i_req_hart;
            addr_q    <= i_req_addr;
            funct_q   <= i_req_funct;
            operand_q <= i_req_operand;
            retry_q   <= '0;
          end
        end
        S_CALC: begin
          old_q <= i_mem_rdata;
          new_q <= amo_result;
        end
        S_CHK: begin
          if (i_rs_sc_success) begin
            fail_q <= 1'b0;
          end else if (retry_left) begin
            retry_q <= retry_q + RETRY_W'(1);
`ifdef AMO_BACKOFF_EN
            backoff_q <= backoff_load;
`endif
          end else begin
            fail_q <= 1'b1;
          end
        end
`ifdef AMO_BACKOFF_EN
        S_BACKOFF: if (backoff_q != '0) backoff_q <= backoff_q - BO_W'(1);
`endif
        default: ;
      endcase
    end
  end

  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = new_q;
  assign o_rs_addr    = addr_q;
  assign o_rs_mhartid = hart_q;
  assign o_resp_hart  = hart_q;
  assign o_resp_rdata = old_q;
  assign o_resp_fail  = fail_q;

endmodule

// File: doc/amo_lrsc_sequencer.md
Name: amo_lrsc_sequencer

Overview:
Initiator side of the LR/SC reservation protocol. Executes one atomic read-modify-write (AMO) request at a time as an LR → compute → SC sequence with bounded retry. Drives the reservation set's load-reserved/store-conditional strobes, address and hart ID, and consumes its registered SC-success result. Owns the data-memory port while busy and returns the pre-update memory value to the requesting hart.

Parameters:
- NUM_THREADS, 16, number of harts; hart ID width is $clog2(NUM_THREADS).
- ADDR_WIDTH, 12, word address width; must match the reservation set address width.
- DATA_WIDTH, 32, data width.
- MAX_RETRIES, 7, SC retries after the first attempt before the request is reported as failed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  AMO request valid
- o_req_ready  out  1  sequencer idle; request accepted when valid && ready
- i_req_hart  in  $clog2(NUM_THREADS)  requesting hart ID
- i_req_addr  in  ADDR_WIDTH  target word address
- i_req_funct  in  4  operation code
- i_req_operand  in  DATA_WIDTH  rs2 operand
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_we  out  1  memory write strobe
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  read data, valid 1 cycle after the address
- o_rs_addr  out  ADDR_WIDTH  reservation set address
- o_rs_mhartid  out  $clog2(NUM_THREADS)  reservation set hart ID
- o_rs_load_reserved_op  out  1  LR strobe
- o_rs_store_cond_op  out  1  SC strobe
- i_rs_sc_success  in  1  SC result, valid 1 cycle after the SC strobe
- o_resp_valid  out  1  response valid
- i_resp_ready  in  1  response accepted
- o_resp_hart  out  $clog2(NUM_THREADS)  hart of the response
- o_resp_rdata  out  DATA_WIDTH  old memory value from the last LR
- o_resp_fail  out  1  1 = retries exhausted; memory not modified

Behaviour:
- Reset (clk, synchronous, active-high):
  - State → IDLE; retry counter = 0.
  - All strobes, o_resp_valid and o_resp_fail = 0; data/address outputs = 0.
  - Reset mid-sequence aborts without a memory write. A reservation already taken remains in the reservation set.
- o_rs_addr and o_mem_addr are driven from the latched address; o_rs_mhartid from the latched hart.
- IDLE:
  - o_req_ready = 1.
  - On valid && ready: latch hart, address, funct and operand; clear the retry counter; go to LR.
- LR (1 cycle): o_rs_load_reserved_op = 1; memory read of the address; go to CALC.
- CALC (1 cycle):
  - old ← i_mem_rdata.
  - new ← f(old, operand), registered.
  - funct encoding: 0 SWAP (new = operand), 1 ADD (mod 2^DATA_WIDTH), 2 XOR, 3 AND, 4 OR, 5 MIN (signed), 6 MAX (signed), 7 MINU, 8 MAXU.
  - Codes 9–15 behave as SWAP.
  - Go to SC.
- SC (1 cycle): o_rs_store_cond_op = 1; go to CHK.
- CHK (1 cycle), sampling i_rs_sc_success:
  - 1: o_mem_we = 1 with o_mem_wdata = new (same cycle); fail ← 0; go to RESP.
  - 0 and retry counter < MAX_RETRIES: counter += 1; go to LR (or BACKOFF when enabled).
  - 0 and counter == MAX_RETRIES: fail ← 1; no write; go to RESP.
- RESP:
  - o_resp_valid = 1; o_resp_rdata = old; o_resp_hart and o_resp_fail are stable.
  - Held until i_resp_ready; on the handshake cycle go to IDLE.
  - No new request is accepted in the same cycle.
- Uncontended latency: accept at cycle 0 → LR c1, CALC c2, SC c3, CHK/write c4, resp_valid c5.
- Each retry adds 4 cycles.
- Strobes are single-cycle and mutually exclusive. o_mem_we is asserted only in CHK on success.
- The reservation set grants only one reservation at a time. An LR while another hart holds it yields SC failure, which is handled by retry.

Optional Feature:
Macro AMO_BACKOFF_EN.
- Defined: a failed SC with retries remaining goes to a BACKOFF state. BACKOFF waits (hart ID + 1) × retry-count cycles, with no strobes asserted, then goes to LR. This staggers competing harts.
- Undefined: BACKOFF state and its counter are absent; retry goes directly CHK → LR.

Test Plan:
- Uncontended ADD: mem[0x010] = 5, hart 3, operand 7 → LR c1, SC c3, write 12 at c4, resp c5 with rdata = 5, fail = 0, hart = 3.
- Signed vs unsigned: mem = 0xFFFFFFFF, operand 1.
  - MIN → writes 0xFFFFFFFF.
  - MINU → writes 1.
  - Both return rdata = 0xFFFFFFFF.
- Single retry: i_rs_sc_success = 0 on the first CHK, 1 on the second → two LR strobes, one write, resp at c9 (without AMO_BACKOFF_EN), fail = 0.
- Exhaustion: i_rs_sc_success held 0 with MAX_RETRIES = 7 → 8 SC strobes, no o_mem_we, resp fail = 1, rdata = value from the last LR.
- Response backpressure: i_resp_ready low for 3 cycles → resp_valid and data stable, o_req_ready = 0 throughout; ready returns the cycle after the handshake.
- Reset asserted in CALC → next cycle IDLE, o_mem_we never asserted, memory unchanged; a new request then completes normally.
